// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for nibble_serial_adder.
// Handshake rule for both channels: a transfer happens on a rising clk edge where valid and ready are both 1; the sender holds its data stable while valid is 1 and ready is 0.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder: one 4-bit slice processes the operands a nibble per cycle,
// least-significant first, with the inter-nibble carry held in a register.
module binary_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] s,
  output logic       carry_out
);
  assign {carry_out, s} = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus,
  output logic [1:0]           fsm_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          cout_q;
  logic [CW-1:0] k;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [3:0]    s_nib;
  logic          c_nib;

  // Nibble k of the captured operands feeds the single slice.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k == CW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  binary_adder u_slice (
    .a         (a_nib),
    .b         (b_nib),
    .carry_in  (carry_q),
    .s         (s_nib),
    .carry_out (c_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            k       <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (k == CW'(i)) sum_q[4*i +: 4] <= s_nib;
          end
          carry_q <= c_nib;
          // Exit on the last nibble so the counter never steps past NIBBLES-1.
          if (k == LAST) begin
            cout_q <= c_nib;
            state  <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign fsm_state     = state;

  a_no_overlap: assert property (@(posedge clk) !(bus.in_ready && bus.out_valid));

  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (state == DONE && !bus.out_ready) |=> (state == DONE && $stable(sum_q) && $stable(cout_q)));
endmodule
